// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, IR latch, and a single-outstanding memory handshake with timeout.
// Optional build macro IF_MISALIGN_CHECK_EN rejects fetches from a misaligned pc instead of masking the address.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IR_Write,
    input  logic        PC_Write,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        fetch_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

`ifdef IF_MISALIGN_CHECK_EN
    localparam logic [1:0] ADDR_LSB_MASK = 2'b11;
`else
    localparam logic [1:0] ADDR_LSB_MASK = 2'b00;
`endif

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= NOP;
            imem_req   <= 1'b0;
            imem_addr  <= {RESET_PC[31:2], RESET_PC[1:0] & ADDR_LSB_MASK};
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            wait_cnt   <= '0;
            pending    <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (IR_Write) begin
`ifdef IF_MISALIGN_CHECK_EN
                        if (pc[1:0] != 2'b00) begin
                            ir        <= NOP;
                            fetch_err <= 1'b1;
                            state     <= DONE;
                        end else
`endif
                        begin
                            state     <= WAIT;
                            imem_req  <= 1'b1;
                            imem_addr <= {pc[31:2], pc[1:0] & ADDR_LSB_MASK};
                            wait_cnt  <= '0;
                        end
                        // The fetch must use the current pc, so the advance is deferred.
                        if (PC_Write)
                            pending <= 1'b1;
                    end else if (PC_Write) begin
                        pc <= pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (PC_Write)
                        pending <= 1'b1;
                    if (imem_ack) begin
                        ir         <= imem_rdata;
                        imem_req   <= 1'b0;
                        fetch_done <= 1'b1;
                        state      <= DONE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        ir        <= NOP;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // A PC_Write arriving in DONE merges with any pending one.
                    if (pending || PC_Write)
                        pc <= pc + 32'd4;
                    pending <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        fetch_busy = (state != IDLE);
        opcode     = ir[6:0];
        rd         = ir[11:7];
        funct3     = ir[14:12];
        rs1        = ir[19:15];
        rs2        = ir[24:20];
        funct7     = ir[31:25];
    end

endmodule
